// File: rtl/uart_rx_fifo_receiver_pkg.sv
// uart_rx_fifo_receiver_pkg: line-format encodings, FSM states and vote helper shared by the UART RX/TX paths
package uart_rx_fifo_receiver_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] DNUM_5 = 2'b00;
    localparam logic [1:0] DNUM_6 = 2'b01;
    localparam logic [1:0] DNUM_7 = 2'b10;
    localparam logic [1:0] DNUM_8 = 2'b11;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO with occupancy/full/empty status
// Ports: clk_i/rst_i (async active-high), push_i+wdata_i write side,
//        pop_i read strobe (ignored when empty), rdata_o head (0 when empty),
//        count_o occupancy, full_o, empty_o.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i & ~empty_o;
    // a push into a full FIFO is accepted only if a pop frees the slot in the same cycle
    assign do_push = push_i & (~full_o | do_pop);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo_receiver.sv
// uart_rx_fifo_receiver: oversampled UART receiver feeding a tagged FWFT word FIFO
// Ports: clk_rx oversampling clock, reset async active-high, rx raw line,
//        d_num/par/s_num frame format (latched at start edge), rd_ready pop,
//        ovr_clr clears overrun; dout/word_err FIFO head, rd_valid not-empty,
//        overrun sticky drop flag, break_det break pulse, fifo_count occupancy.
module uart_rx_fifo_receiver
    import uart_rx_fifo_receiver_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_rx,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [1:0]                    d_num,
    input  logic [1:0]                    par,
    input  logic                          s_num,
    input  logic                          rd_ready,
    input  logic                          ovr_clr,
    output logic [7:0]                    dout,
    output logic                          rd_valid,
    output logic [1:0]                    word_err,
    output logic                          overrun,
    output logic                          break_det,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_H0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_H1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_H2   = CW'(OVERSAMPLE / 2 + 1);

    logic [1:0]  sync_q;
    logic        rx_s;
    rx_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]  s_q;
    logic        maj_q, maj_now, at_last;
    logic [2:0]  bit_q;
    logic [7:0]  data_q;
    logic [1:0]  dn_q, par_cfg_q;
    logic        sn_q;
    logic        par_err_q, frame_err_q, brk_q, armed_q;
    logic        push_q, brk_det_q;
    logic [9:0]  wdata_q;
    logic        fifo_full, fifo_empty, drop;
    logic [9:0]  head;
    logic        overrun_q;

    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx};
    end

    assign rx_s    = sync_q[1];
    assign at_last = cnt_q == C_LAST;
    // third vote sample is live at H+1, which is when the stop bits are decided
    assign maj_now = maj3(s_q[0], s_q[1], rx_s);

    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            s_q         <= 2'b00;
            maj_q       <= 1'b0;
            bit_q       <= '0;
            data_q      <= '0;
            dn_q        <= DNUM_8;
            par_cfg_q   <= PAR_NONE;
            sn_q        <= STOP_1;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            brk_q       <= 1'b0;
            armed_q     <= 1'b1;
            push_q      <= 1'b0;
            brk_det_q   <= 1'b0;
            wdata_q     <= '0;
        end else begin
            push_q    <= 1'b0;
            brk_det_q <= 1'b0;
            cnt_q     <= at_last ? '0 : cnt_q + CW'(1);
            if (cnt_q == C_H0) s_q[0] <= rx_s;
            if (cnt_q == C_H1) s_q[1] <= rx_s;
            if (cnt_q == C_H2) maj_q <= maj_now;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // after a break the line must return high before a new start is accepted
                    if (rx_s) armed_q <= 1'b1;
                    else if (armed_q) begin
                        state_q     <= S_START;
                        dn_q        <= d_num;
                        par_cfg_q   <= par;
                        sn_q        <= s_num;
                        data_q      <= '0;
                        bit_q       <= '0;
                        par_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        brk_q       <= 1'b1;
                    end
                end
                S_START: if (at_last) state_q <= maj_q ? S_IDLE : S_DATA;
                S_DATA: if (at_last) begin
                    data_q[bit_q] <= maj_q;
                    brk_q         <= brk_q & ~maj_q;
                    bit_q         <= bit_q + 3'd1;
                    // last data bit index is d_num+4
                    if (bit_q == {1'b1, dn_q})
                        state_q <= (par_cfg_q == PAR_EVEN || par_cfg_q == PAR_ODD) ? S_PARITY : S_STOP1;
                end
                S_PARITY: if (at_last) begin
                    par_err_q <= (^data_q ^ maj_q) != (par_cfg_q == PAR_ODD);
                    brk_q     <= brk_q & ~maj_q;
                    state_q   <= S_STOP1;
                end
                S_STOP1: begin
                    if (sn_q == STOP_1 && cnt_q == C_H2) begin
                        push_q    <= 1'b1;
                        wdata_q   <= {par_err_q, frame_err_q | ~maj_now, data_q};
                        brk_det_q <= brk_q & ~maj_now;
                        armed_q   <= ~(brk_q & ~maj_now);
                        state_q   <= S_IDLE;
                    end else if (sn_q == STOP_2 && at_last) begin
                        frame_err_q <= frame_err_q | ~maj_q;
                        brk_q       <= brk_q & ~maj_q;
                        state_q     <= S_STOP2;
                    end
                end
                S_STOP2: if (cnt_q == C_H2) begin
                    push_q    <= 1'b1;
                    wdata_q   <= {par_err_q, frame_err_q | ~maj_now, data_q};
                    brk_det_q <= brk_q;
                    armed_q   <= ~brk_q;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_rx),
        .rst_i   (reset),
        .push_i  (push_q),
        .wdata_i (wdata_q),
        .pop_i   (rd_ready),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign drop = push_q & fifo_full & ~rd_ready;

    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset)        overrun_q <= 1'b0;
        else if (drop)    overrun_q <= 1'b1;
        else if (ovr_clr) overrun_q <= 1'b0;
    end

    assign dout      = head[7:0];
    assign word_err  = head[9:8];
    assign rd_valid  = ~fifo_empty;
    assign overrun   = overrun_q;
    assign break_det = brk_det_q;

endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// tb_uart_rx_fifo_receiver: directed scenario bench for the UART receiver with FIFO
module tb_uart_rx_fifo_receiver;

    logic       clk_rx = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [1:0] d_num = 2'b11;
    logic [1:0] par = 2'b00;
    logic       s_num = 1'b0;
    logic       rd_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] dout;
    logic       rd_valid;
    logic [1:0] word_err;
    logic       overrun;
    logic       break_det;
    logic [3:0] fifo_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_rx_fifo_receiver #(.OVERSAMPLE(16), .FIFO_DEPTH(8)) dut (
        .clk_rx     (clk_rx),
        .reset      (reset),
        .rx         (rx),
        .d_num      (d_num),
        .par        (par),
        .s_num      (s_num),
        .rd_ready   (rd_ready),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .rd_valid   (rd_valid),
        .word_err   (word_err),
        .overrun    (overrun),
        .break_det  (break_det),
        .fifo_count (fifo_count)
    );

    always #5 clk_rx = ~clk_rx;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_rx);
            #1;
        end
    endtask

    task automatic send_head(input logic [7:0] data, input int nbits, input int pm,
                             input logic pflip, input logic [1:0] mid_dnum, input int gbit);
        rx = 1'b0;
        tick(16);
        d_num = mid_dnum;
        for (int i = 0; i < nbits; i++) begin
            if (i == gbit) begin
                rx = data[i];
                tick(9);
                rx = ~data[i];
                tick(1);
                rx = data[i];
                tick(6);
            end else begin
                rx = data[i];
                tick(16);
            end
        end
        if (pm != 0) begin
            rx = (^data) ^ (pm == 2) ^ pflip;
            tick(16);
        end
    endtask

    task automatic send_stops(input int nstop, input logic s2low, input int idle);
        rx = 1'b1;
        tick(16);
        if (nstop == 2) begin
            rx = ~s2low;
            tick(16);
        end
        rx = 1'b1;
        tick(idle);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total_cnt++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h exp 00", dout); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b00) $display("FAIL reset_word_err: got %b exp 00", word_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b exp 0", overrun); else pass_cnt++;
        total_cnt++; if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d exp 0", fifo_count); else pass_cnt++;
        reset = 1'b0;
        tick(5);
    endtask

    task automatic test_8n1();
        d_num = 2'b11; par = 2'b00; s_num = 1'b0;
        send_head(8'hA5, 8, 0, 1'b0, 2'b11, -1);
        rx = 1'b1;
        tick(13);
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL 8n1_valid_early: got %b exp 0", rd_valid); else pass_cnt++;
        tick(1);
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL 8n1_valid_after_push: got %b exp 1", rd_valid); else pass_cnt++;
        tick(2 + 30);
        total_cnt++; if (dout !== 8'hA5) $display("FAIL 8n1_dout: got %h exp a5", dout); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b00) $display("FAIL 8n1_word_err: got %b exp 00", word_err); else pass_cnt++;
        pop_one();
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL 8n1_pop_valid: got %b exp 0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_7e2();
        d_num = 2'b10; par = 2'b01; s_num = 1'b1;
        send_head(8'h41, 7, 1, 1'b1, 2'b10, -1);
        send_stops(2, 1'b0, 40);
        total_cnt++; if (dout !== 8'h41) $display("FAIL 7e2_par_dout: got %h exp 41", dout); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b10) $display("FAIL 7e2_par_err: got %b exp 10", word_err); else pass_cnt++;
        pop_one();
        send_head(8'h41, 7, 1, 1'b0, 2'b10, -1);
        send_stops(2, 1'b1, 40);
        total_cnt++; if (dout !== 8'h41) $display("FAIL 7e2_stop_dout: got %h exp 41", dout); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b01) $display("FAIL 7e2_frame_err: got %b exp 01", word_err); else pass_cnt++;
        total_cnt++; if (fifo_count !== 4'd1) $display("FAIL 7e2_count: got %0d exp 1", fifo_count); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_glitch();
        d_num = 2'b11; par = 2'b00; s_num = 1'b0;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL glitch_no_push: got %b exp 0", rd_valid); else pass_cnt++;
        send_head(8'hA5, 8, 0, 1'b0, 2'b11, 3);
        send_stops(1, 1'b0, 30);
        total_cnt++; if (dout !== 8'hA5) $display("FAIL spike_dout: got %h exp a5", dout); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b00) $display("FAIL spike_word_err: got %b exp 00", word_err); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_5o1_cfg_latch();
        d_num = 2'b00; par = 2'b10; s_num = 1'b0;
        send_head(8'h1F, 5, 2, 1'b0, 2'b11, -1);
        send_stops(1, 1'b0, 30);
        total_cnt++; if (dout !== 8'h1F) $display("FAIL 5o1_dout: got %h exp 1f", dout); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b00) $display("FAIL 5o1_word_err: got %b exp 00", word_err); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_back_to_back();
        d_num = 2'b11; par = 2'b00; s_num = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_head(8'(8'h10 + i), 8, 0, 1'b0, 2'b11, -1);
            send_stops(1, 1'b0, 0);
        end
        tick(40);
        total_cnt++; if (fifo_count !== 4'd8) $display("FAIL b2b_count: got %0d exp 8", fifo_count); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL b2b_overrun: got %b exp 1", overrun); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if (dout !== 8'(8'h10 + i)) $display("FAIL b2b_order[%0d]: got %h exp %h", i, dout, 8'(8'h10 + i)); else pass_cnt++;
            pop_one();
        end
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL b2b_drained: got %b exp 0", rd_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL b2b_overrun_sticky: got %b exp 1", overrun); else pass_cnt++;
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %b exp 0", overrun); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [$];
        d_num = 2'b11; par = 2'b00; s_num = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_head(8'(8'h20 + i), 8, 0, 1'b0, 2'b11, -1);
            send_stops(1, 1'b0, 0);
        end
        send_head(8'h99, 8, 0, 1'b0, 2'b11, -1);
        rx = 1'b1;
        tick(13);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(2 + 40);
        total_cnt++; if (fifo_count !== 4'd8) $display("FAIL fpp_count: got %0d exp 8", fifo_count); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL fpp_overrun: got %b exp 0", overrun); else pass_cnt++;
        for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'h20 + i));
        exp_q.push_back(8'h99);
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if (dout !== exp_q[i]) $display("FAIL fpp_order[%0d]: got %h exp %h", i, dout, exp_q[i]); else pass_cnt++;
            pop_one();
        end
    endtask

    task automatic test_break();
        int pulses;
        pulses = 0;
        d_num = 2'b11; par = 2'b00; s_num = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 480; i++) begin
            tick(1);
            if (break_det === 1'b1) pulses++;
        end
        rx = 1'b1;
        tick(40);
        total_cnt++; if (pulses !== 1) $display("FAIL break_pulses: got %0d exp 1", pulses); else pass_cnt++;
        total_cnt++; if (fifo_count !== 4'd1) $display("FAIL break_count: got %0d exp 1", fifo_count); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00) $display("FAIL break_dout: got %h exp 00", dout); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b01) $display("FAIL break_word_err: got %b exp 01", word_err); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_reset_mid_frame();
        d_num = 2'b11; par = 2'b00; s_num = 1'b0;
        send_head(8'h5A, 8, 0, 1'b0, 2'b11, -1);
        send_stops(1, 1'b0, 20);
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(16);
        rx = 1'b0;
        tick(20);
        reset = 1'b1;
        rx = 1'b1;
        tick(2);
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid: got %b exp 0", rd_valid); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00) $display("FAIL midrst_dout: got %h exp 00", dout); else pass_cnt++;
        total_cnt++; if (fifo_count !== 4'd0) $display("FAIL midrst_count: got %0d exp 0", fifo_count); else pass_cnt++;
        total_cnt++; if (break_det !== 1'b0) $display("FAIL midrst_break: got %b exp 0", break_det); else pass_cnt++;
        reset = 1'b0;
        tick(20);
        send_head(8'h3C, 8, 0, 1'b0, 2'b11, -1);
        send_stops(1, 1'b0, 30);
        total_cnt++; if (dout !== 8'h3C) $display("FAIL midrst_next_dout: got %h exp 3c", dout); else pass_cnt++;
        total_cnt++; if (word_err !== 2'b00) $display("FAIL midrst_next_err: got %b exp 00", word_err); else pass_cnt++;
        total_cnt++; if (fifo_count !== 4'd1) $display("FAIL midrst_next_count: got %0d exp 1", fifo_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_glitch();
        test_5o1_cfg_latch();
        test_back_to_back();
        test_full_push_pop();
        test_break();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_receiver.md
Name: uart_rx_fifo_receiver

Overview:
- Next-generation UART receiver. Oversampled serial input with a 2-flop synchroniser and 3-sample majority vote.
- Runtime-selectable 5–8 data bits, none/even/odd parity and 1/2 stop bits; false-start rejection and break detection.
- Received words are buffered, together with per-word error tags, in a FWFT FIFO with valid/ready handshake. Sits between the pin and the host/bus side of the UART.

Parameters:
- OVERSAMPLE, 16, clk_rx ticks per bit; even, ≥8.
- FIFO_DEPTH, 8, word slots; power of 2, ≥2.

Ports:
- clk_rx  in  1  oversampling clock (one tick = 1/OVERSAMPLE bit)
- reset  in  1  asynchronous, active-high reset
- rx  in  1  raw serial line, idle high, asynchronous to clk_rx
- d_num  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- par  in  2  00 none, 01 even, 10 odd, 11 none
- s_num  in  1  0=one stop bit, 1=two stop bits
- rd_ready  in  1  consumer pop strobe
- ovr_clr  in  1  clears the overrun flag
- dout  out  8  FIFO head data; unused MSBs are 0
- rd_valid  out  1  FIFO not empty
- word_err  out  2  head tag {par_err, frame_err}
- overrun  out  1  sticky: a word was dropped because the FIFO was full
- break_det  out  1  one-cycle pulse on break frame
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (async, any time, including mid-frame): FSM→IDLE, counters 0, FIFO emptied, dout=0, rd_valid=0, word_err=0, overrun=0, break_det=0. Synchroniser flops reset to 1.
- rx_s is rx after two flops (2-cycle latency). All decisions use rx_s.
- cnt runs 0..OVERSAMPLE-1 within each bit. Samples are taken at H-1, H, H+1 with H=OVERSAMPLE/2; bit value = majority of the three.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: rx_s==0 → START with cnt=0. Latch d_num/par/s_num here; later config changes do not affect the frame in flight.
- START: at cnt==OVERSAMPLE-1, majority 1 → IDLE (false start, nothing pushed). Otherwise → DATA.
- DATA: LSB first. Shift in at cnt==OVERSAMPLE-1. After the final bit → PARITY if par is 01/10, else STOP1.
- PARITY: even requires ^data ^ bit == 0; odd requires 1. Mismatch sets frame par_err. Compute over the active bits only.
- STOP1 (one stop bit, s_num=0): decide at cnt==H+1, then → IDLE. This early exit allows resync to a back-to-back start edge.
- STOP1 (s_num=1): decide at cnt==OVERSAMPLE-1, then → STOP2. STOP2 decides at cnt==H+1, then → IDLE.
- Any stop sample 0 sets frame_err.
- Push at the final stop decision: entry {par_err, frame_err, data zero-extended}. Flags are per frame and cleared at START entry.
- Break: data all 0, parity bit 0 if present, and first stop 0 → break_det pulses the same cycle as the push. The word is still pushed with frame_err=1. Re-arm only after rx_s is seen high in IDLE; no repeated pushes while the line is held low.
- FIFO, first-word-fall-through: dout/word_err always show the head; rd_valid = count≠0.
- Pop occurs when rd_valid&&rd_ready; rd_ready while empty is ignored. A pushed word is visible on rd_valid the cycle after the push edge.
- Push while full with no pop: word dropped, overrun←1.
- Push and pop in the same cycle while full: both execute, no overrun, count unchanged.
- overrun stays set until ovr_clr. If ovr_clr coincides with a new drop, set wins.
- Pointers wrap modulo FIFO_DEPTH; count saturates 0..FIFO_DEPTH.

Decomposition:
- Shared include uart_defs.vh: PAR_NONE/EVEN/ODD, DNUM_5..DNUM_8, STOP_1/STOP_2, FSM state encodings. These encodings are shared with the future transmitter.
- Sub-module uart_sync_fifo(WIDTH=10, DEPTH), FWFT, with count/full/empty outputs. Reusable by the TX path.

Test Plan:
- 8N1 0xA5, OVERSAMPLE=16 → one push; dout=0xA5, word_err=00, rd_valid asserts exactly 1 cycle after the push edge; rd_ready pop → rd_valid=0.
- 7E2 0x41 with wrong parity bit → dout=0x41, word_err=10. Repeat with second stop forced low → word_err=01.
- rx low for 5 ticks then high (glitch) → no push, FSM back in IDLE. Single-tick spike at a data-bit centre → majority corrects, data intact.
- 5O1 0x1F, then d_num changed to 11 mid-frame → received as 5 bits, dout=0x1F, upper bits 0, no parity error.
- 9 back-to-back 8N1 frames, no reads, FIFO_DEPTH=8 → count=8, overrun=1, first 8 words read in order. ovr_clr → overrun=0. Full+push+pop in one cycle → no overrun.
- rx held low 3 frame-times → exactly one push 0x00/word_err=01, one break_det pulse. Reset asserted mid-frame → all outputs 0, next clean frame received correctly.
